piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- It is the transmit end of the single-bit serial link whose receive end is a chain of D flip-flops capturing one bit per clock edge.
- Used by downstream shift-register/receiver blocks and their benches as a clean, framed bit source.

---
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer.sv | 92 +++++++++
 tb/tb_piso_serializer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The master side is the word producer and serial observer; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid, data_in,
        input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  load_valid, data_in,
        output load_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// LSB-first parallel-in/serial-out transmitter with valid/ready load and frame markers.
// Define PISO_PARITY_EN to append an even-parity bit after the data MSB.
module piso_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              reset,
    piso_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [FRAME-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [FRAME-1:0] load_word;
    logic             at_last;
    logic             ready;
    logic             transfer;

`ifdef PISO_PARITY_EN
    assign load_word = {^bus.data_in, bus.data_in};
`else
    assign load_word = bus.data_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        at_last  = (state == SHIFT) && (cnt == LAST_CNT);
        ready    = (state == IDLE) || at_last;
        transfer = bus.load_valid && ready;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_n = SHIFT;
                    shreg_n = load_word;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    // Reloading in the last-bit cycle keeps frames gapless.
                    if (transfer) begin
                        shreg_n = load_word;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                        shreg_n = '0;
                        cnt_n   = '0;
                    end
                end else begin
                    shreg_n = shreg >> 1;
                    cnt_n   = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                shreg_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches ser_* combinationally.
    assign bus.load_ready = ready;
    assign bus.ser_valid  = (state == SHIFT);
    assign bus.ser_out    = (state == SHIFT) && shreg[0];
    assign bus.ser_first  = (state == SHIFT) && (cnt == '0);
    assign bus.ser_last   = at_last;
    assign bus.busy       = (state == SHIFT);
endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=8); parity frames
// are exercised when PISO_PARITY_EN is defined.
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = 9;
`else
    localparam int unsigned FRAME = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    piso_serializer_if #(.WIDTH(8)) bus ();

    piso_serializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] w);
`ifdef PISO_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.ser_valid), 32'd0);
        check({tag, "_out"},   32'(bus.ser_out),   32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
        check({tag, "_first"}, 32'(bus.ser_first), 32'd0);
        check({tag, "_last"},  32'(bus.ser_last),  32'd0);
    endtask

    // Load one word, then check every bit; optionally drive junk loads while busy.
    task automatic run_frame(input string tag, input logic [7:0] w, input bit noisy);
        logic [FRAME-1:0] exp;
        exp = frame_bits(w);
        bus.load_valid = 1'b1;
        bus.data_in    = w;
        tick();
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        for (int k = 0; k < FRAME; k++) begin
            check({tag, "_valid"}, 32'(bus.ser_valid), 32'd1);
            check({tag, "_bit"},   32'(bus.ser_out),   32'(exp[k]));
            check({tag, "_first"}, 32'(bus.ser_first), 32'(k == 0));
            check({tag, "_last"},  32'(bus.ser_last),  32'(k == FRAME - 1));
            check({tag, "_ready"}, 32'(bus.load_ready), 32'(k == FRAME - 1));
            check({tag, "_busy"},  32'(bus.busy),      32'd1);
            if (noisy && k >= 1 && k <= FRAME - 2) begin
                bus.load_valid = 1'b1;
                bus.data_in    = 8'h33;
            end else begin
                bus.load_valid = 1'b0;
                bus.data_in    = '0;
            end
            tick();
        end
        check_idle({tag, "_after"});
    endtask

    initial begin
        logic [2*FRAME-1:0] stream;

        // Reset with a pending load: the word must be dropped.
        reset          = 1'b1;
        bus.load_valid = 1'b1;
        bus.data_in    = 8'hFF;
        tick();
        tick();
        check_idle("rst");
        reset          = 1'b0;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_release_valid", 32'(bus.ser_valid), 32'd0);
        end

        run_frame("a5", 8'hA5, 1'b0);
        run_frame("a5_noisy", 8'hA5, 1'b1);

        // Back-to-back 0x0F then 0xF0 with load_valid held through the first frame.
        stream         = {frame_bits(8'hF0), frame_bits(8'h0F)};
        bus.load_valid = 1'b1;
        bus.data_in    = 8'h0F;
        tick();
        bus.data_in    = 8'hF0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            check("b2b_valid", 32'(bus.ser_valid), 32'd1);
            check("b2b_bit",   32'(bus.ser_out),   32'(stream[k]));
            check("b2b_first", 32'(bus.ser_first), 32'(k == 0 || k == FRAME));
            check("b2b_last",  32'(bus.ser_last),  32'(k == FRAME - 1 || k == 2 * FRAME - 1));
            check("b2b_ready", 32'(bus.load_ready), 32'(k == FRAME - 1 || k == 2 * FRAME - 1));
            if (k == FRAME) begin
                bus.load_valid = 1'b0;
                bus.data_in    = '0;
            end
            tick();
        end
        check_idle("b2b_after");

        // Reset during bit 3 of 0xFF aborts the frame.
        bus.load_valid = 1'b1;
        bus.data_in    = 8'hFF;
        tick();
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        for (int k = 0; k < 3; k++) begin
            check("abort_bit", 32'(bus.ser_out), 32'd1);
            tick();
        end
        check("abort_bit3", 32'(bus.ser_out), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        tick();
        check("abort_stay_idle", 32'(bus.ser_valid), 32'd0);
        run_frame("x01", 8'h01, 1'b0);

`ifdef PISO_PARITY_EN
        run_frame("par07", 8'h07, 1'b0);
        check("par07_bit", 32'(frame_bits(8'h07)), 32'h107);
        run_frame("para5", 8'hA5, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
